// File: rtl/dat_serializer.sv
// SD card DAT-line block serializer.
// Shifts 32-bit buffer words out on DAT0 (1-bit mode) or DAT3..0 (4-bit mode),
// framed by a start bit, a per-line CRC16 and an end bit. All DAT line changes
// are paced by bit_en_i; a missing buffer word stalls the stream losslessly.
//
// Buffer handshake: word_i is taken in exactly the cycle word_ack_o is high,
// and word_ack_o is only raised while word_valid_i is high; the buffer must
// hold word_i stable while word_valid_i is high and advance after an ack.
module dat_serializer #(
   parameter int BLK_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bit_en_i,
   input  logic             start_i,
   input  logic             wide_i,
   input  logic [BLK_W-1:0] words_i,
   input  logic [31:0]      word_i,
   input  logic             word_valid_i,
   output logic             word_ack_o,
   output logic [3:0]       dat_o,
   output logic             dat_oe_o,
   output logic             busy_o,
   output logic             stall_o,
   output logic             done_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      CRC   = 3'd4,
      END   = 3'd5
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             wide_q;
   logic [BLK_W-1:0] words_left;
   logic [31:0]      shreg;
   logic [4:0]       bit_cnt;
   logic [15:0]      crc_q [4];
   logic [3:0]       dat_q;
   logic             oe_q;
   logic             done_q;

   logic             last_bit;
   logic             need_word;
   logic             step;

   // One serial step of CRC16 x^16+x^12+x^5+1.
   function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   // Word-boundary detection, stall and the single step qualifier used by the datapath.
   always_comb begin
      last_bit   = wide_q ? (bit_cnt == 5'd7) : (bit_cnt == 5'd31);
      need_word  = (state == DATA) && last_bit && (words_left != '0);
      stall_o    = need_word && !word_valid_i;
      step       = bit_en_i && !stall_o;
      word_ack_o = ((state == FETCH) && word_valid_i) ||
                   (need_word && word_valid_i && bit_en_i);
   end

   assign busy_o   = (state != IDLE);
   assign dat_o    = dat_q;
   assign dat_oe_o = oe_q;
   assign done_o   = done_q;

   // State register; reset wins over everything, including start_i.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic; transitions on the DAT line follow the bit-time strobe.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (start_i && (words_i != '0)) state_next = FETCH;
         FETCH: if (word_valid_i) state_next = START;
         START: if (bit_en_i) state_next = DATA;
         DATA:  if (step && last_bit && (words_left == '0)) state_next = CRC;
         CRC:   if (step && (bit_cnt == 5'd15)) state_next = END;
         END:   if (bit_en_i && (bit_cnt == 5'd1)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: block parameters, shift register, counters, CRCs and DAT outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         wide_q     <= 1'b0;
         words_left <= '0;
         shreg      <= '0;
         bit_cnt    <= '0;
         dat_q      <= 4'hF;
         oe_q       <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < 4; i++) crc_q[i] <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i && (words_i != '0)) begin
                  wide_q     <= wide_i;
                  words_left <= words_i;
                  bit_cnt    <= '0;
                  for (int i = 0; i < 4; i++) crc_q[i] <= '0;
               end
            end
            FETCH: begin
               if (word_valid_i) shreg <= word_i;
            end
            START: begin
               if (bit_en_i) begin
                  dat_q <= wide_q ? 4'h0 : 4'hE;
                  oe_q  <= 1'b1;
               end
            end
            DATA: begin
               if (step) begin
                  dat_q <= wide_q ? shreg[31:28] : {3'b111, shreg[31]};
                  if (wide_q) begin
                     for (int i = 0; i < 4; i++) crc_q[i] <= crc16_step(crc_q[i], shreg[28+i]);
                  end else begin
                     crc_q[0] <= crc16_step(crc_q[0], shreg[31]);
                  end
                  if (last_bit) begin
                     bit_cnt <= '0;
                     if (word_ack_o) shreg <= word_i;
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                     shreg   <= wide_q ? {shreg[27:0], 4'h0} : {shreg[30:0], 1'b0};
                  end
               end
            end
            CRC: begin
               if (step) begin
                  dat_q <= wide_q ? {crc_q[3][15], crc_q[2][15], crc_q[1][15], crc_q[0][15]}
                                  : {3'b111, crc_q[0][15]};
                  for (int i = 0; i < 4; i++) crc_q[i] <= {crc_q[i][14:0], 1'b0};
                  bit_cnt <= (bit_cnt == 5'd15) ? 5'd0 : bit_cnt + 5'd1;
               end
            end
            END: begin
               // First bit-time drives the end bit, the next one releases the bus.
               if (bit_en_i) begin
                  dat_q <= 4'hF;
                  if (bit_cnt == 5'd0) begin
                     bit_cnt <= 5'd1;
                  end else begin
                     bit_cnt <= 5'd0;
                     oe_q    <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: begin
               dat_q <= 4'hF;
               oe_q  <= 1'b0;
            end
         endcase
         if (word_ack_o) words_left <= words_left - 1'b1;
      end
   end

endmodule

// File: tb/tb_dat_serializer.sv
// Self-checking bench for dat_serializer: a scoreboard of expected DAT values
// is built from the block contents when a block is started and compared
// against every bit-time the DUT emits.
module tb_dat_serializer;

   logic        clk;
   logic        reset;
   logic        bit_en_i;
   logic        start_i;
   logic        wide_i;
   logic [9:0]  words_i;
   logic [31:0] word_i;
   logic        word_valid_i;
   logic        word_ack_o;
   logic [3:0]  dat_o;
   logic        dat_oe_o;
   logic        busy_o;
   logic        stall_o;
   logic        done_o;

   dat_serializer #(.BLK_W(10)) dut (
      .clk          (clk),
      .reset        (reset),
      .bit_en_i     (bit_en_i),
      .start_i      (start_i),
      .wide_i       (wide_i),
      .words_i      (words_i),
      .word_i       (word_i),
      .word_valid_i (word_valid_i),
      .word_ack_o   (word_ack_o),
      .dat_o        (dat_o),
      .dat_oe_o     (dat_oe_o),
      .busy_o       (busy_o),
      .stall_o      (stall_o),
      .done_o       (done_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard state ----------------
   logic [3:0]  exp_q[$];   // expected DAT value per bit-time
   logic [31:0] src_q[$];   // words offered by the buffer model
   logic [31:0] blk_q[$];   // words of the block under test
   int          en_period = 1;
   bit          mon_en = 0;
   int          emitted = 0;
   int          ack_cnt = 0;
   int          done_cnt = 0;
   int          oe_cycles = 0;
   int          stall_cycles = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference CRC16 (x^16+x^12+x^5+1) written with explicit taps.
   function automatic logic [15:0] crc_model(input logic [15:0] c, input logic b);
      logic        fb;
      logic [15:0] n;
      fb    = c[15] ^ b;
      n     = c << 1;
      n[0]  = fb;
      n[5]  = c[4] ^ fb;
      n[12] = c[11] ^ fb;
      return n;
   endfunction

   // Build the full expected DAT stream for blk_q.
   task automatic build_expected(input logic wide, input bit use_known, input logic [15:0] known);
      logic [15:0] crc [4];
      logic [31:0] w;
      logic [3:0]  nib;
      for (int i = 0; i < 4; i++) crc[i] = '0;
      exp_q.push_back(wide ? 4'h0 : 4'hE);
      foreach (blk_q[k]) begin
         w = blk_q[k];
         if (wide) begin
            for (int n = 7; n >= 0; n--) begin
               nib = w[n*4 +: 4];
               exp_q.push_back(nib);
               for (int i = 0; i < 4; i++) crc[i] = crc_model(crc[i], nib[i]);
            end
         end else begin
            for (int b = 31; b >= 0; b--) begin
               exp_q.push_back({3'b111, w[b]});
               crc[0] = crc_model(crc[0], w[b]);
            end
         end
      end
      if (use_known) crc[0] = known;
      for (int k = 15; k >= 0; k--) begin
         if (wide) exp_q.push_back({crc[3][k], crc[2][k], crc[1][k], crc[0][k]});
         else      exp_q.push_back({3'b111, crc[0][k]});
      end
      exp_q.push_back(4'hF);
   endtask

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Buffer model: offers src_q head, pops it after an observed ack.
   initial begin
      logic ack_now;
      word_valid_i = 1'b0;
      word_i       = '0;
      forever begin
         @(negedge clk);
         ack_now = word_ack_o;
         @(posedge clk);
         #1;
         if (ack_now === 1'b1 && src_q.size() > 0) void'(src_q.pop_front());
         if (src_q.size() > 0) begin
            word_valid_i = 1'b1;
            word_i       = src_q[0];
         end else begin
            word_valid_i = 1'b0;
            word_i       = $urandom;
         end
      end
   end

   // Bit-time strobe generator.
   initial begin
      int cyc;
      cyc      = 0;
      bit_en_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         bit_en_i = (en_period <= 1) ? 1'b1 : ((cyc % en_period) == 0);
      end
   end

   task automatic pulse_start(input logic wide, input int words);
      tick();
      start_i = 1'b1;
      wide_i  = wide;
      words_i = 10'(words);
      tick();
      start_i = 1'b0;
      wide_i  = 1'($urandom);
      words_i = 10'($urandom);
   endtask

   task automatic wait_done(input int budget, input string tag);
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         tick();
         n++;
      end
      tick();
      tick();
      check(tag, 32'(done_cnt - d0), 32'd1);
      check({tag, "_busy"}, 32'(busy_o), 32'd0);
      check({tag, "_oe"}, 32'(dat_oe_o), 32'd0);
      check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Full block with all words available up front; returns counter deltas.
   task automatic run_block(input logic wide, input int period, input string tag,
                            input bit use_known, input logic [15:0] known,
                            output int d_emit, output int d_ack, output int d_oe);
      int e0, a0, o0;
      en_period = period;
      build_expected(wide, use_known, known);
      foreach (blk_q[k]) src_q.push_back(blk_q[k]);
      e0 = emitted; a0 = ack_cnt; o0 = oe_cycles;
      pulse_start(wide, blk_q.size());
      wait_done(20000, tag);
      d_emit = emitted - e0;
      d_ack  = ack_cnt - a0;
      d_oe   = oe_cycles - o0;
   endtask

   // ---------------- monitor / scoreboard compare ----------------
   logic       p_step;
   logic       p_reset;
   logic       p_oe;
   logic [3:0] last_dat;

   always @(negedge clk) begin
      logic [3:0] e;
      if (mon_en) begin
         if (!p_reset && p_step && dat_oe_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("extra_bit", 32'(dat_o), 32'hF0);
            end else begin
               e = exp_q.pop_front();
               check("dat", 32'(dat_o), 32'(e));
               emitted++;
            end
         end else if (!p_reset && p_oe && dat_oe_o === 1'b1) begin
            check("hold", 32'(dat_o), 32'(last_dat));
         end
         if (dat_oe_o !== 1'b1) check("idle_dat", 32'(dat_o), 32'hF);
         if (stall_o === 1'b1)    stall_cycles++;
         if (done_o === 1'b1)     done_cnt++;
         if (word_ack_o === 1'b1) ack_cnt++;
         if (dat_oe_o === 1'b1)   oe_cycles++;
      end
      last_dat = dat_o;
      p_oe     = dat_oe_o;
      p_step   = bit_en_i && !stall_o;
      p_reset  = reset;
   end

   // ---------------- test sequence ----------------
   initial begin
      int d_emit, d_ack, d_oe, e0, a0, s0, n, nw, per;
      logic wd;
      reset   = 1'b1;
      start_i = 1'b0;
      wide_i  = 1'b0;
      words_i = '0;
      repeat (3) tick();
      mon_en = 1;
      check("rst_dat", 32'(dat_o), 32'hF);
      check("rst_oe", 32'(dat_oe_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_ack", 32'(word_ack_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      reset = 1'b0;
      tick();

      // 1-bit, 128 words of ones: known CRC 16'h7FA1, 4114 bit-times.
      blk_q.delete();
      for (int k = 0; k < 128; k++) blk_q.push_back(32'hFFFFFFFF);
      run_block(1'b0, 1, "ones", 1'b1, 16'h7FA1, d_emit, d_ack, d_oe);
      check("ones_bits", 32'(d_emit), 32'd4114);
      check("ones_oe", 32'(d_oe), 32'd4114);
      check("ones_acks", 32'(d_ack), 32'd128);

      // 4-bit, single word 12345678: 26 bit-times, one ack.
      blk_q.delete();
      blk_q.push_back(32'h12345678);
      run_block(1'b1, 1, "nib", 1'b0, 16'h0, d_emit, d_ack, d_oe);
      check("nib_bits", 32'(d_emit), 32'd26);
      check("nib_acks", 32'(d_ack), 32'd1);

      // 1-bit, 2 words, buffer empty for 10 cycles at the word boundary.
      en_period = 1;
      blk_q.delete();
      blk_q.push_back($urandom);
      blk_q.push_back($urandom);
      build_expected(1'b0, 1'b0, 16'h0);
      src_q.push_back(blk_q[0]);
      e0 = emitted; a0 = ack_cnt; s0 = stall_cycles;
      pulse_start(1'b0, 2);
      n = 0;
      while (stall_o !== 1'b1 && n < 200) begin tick(); n++; end
      check("stall_seen", 32'(stall_o), 32'd1);
      repeat (9) tick();
      src_q.push_back(blk_q[1]);
      wait_done(500, "stall");
      check("stall_len", 32'(stall_cycles - s0), 32'd10);
      check("stall_bits", 32'(emitted - e0), 32'd82);
      check("stall_acks", 32'(ack_cnt - a0), 32'd2);

      // Reset in the middle of the CRC field.
      blk_q.delete();
      blk_q.push_back($urandom);
      build_expected(1'b0, 1'b0, 16'h0);
      src_q.push_back(blk_q[0]);
      e0 = emitted;
      s0 = done_cnt;
      pulse_start(1'b0, 1);
      n = 0;
      while ((emitted - e0) < 38 && n < 300) begin tick(); n++; end
      check("crc_reach", 32'(emitted - e0), 32'd38);
      reset = 1'b1;
      tick();
      check("mid_rst_oe", 32'(dat_oe_o), 32'd0);
      check("mid_rst_dat", 32'(dat_o), 32'hF);
      check("mid_rst_busy", 32'(busy_o), 32'd0);
      check("mid_rst_stall", 32'(stall_o), 32'd0);
      exp_q.delete();
      src_q.delete();
      reset = 1'b0;
      repeat (5) tick();
      check("mid_rst_done", 32'(done_cnt - s0), 32'd0);
      blk_q.delete();
      for (int k = 0; k < 3; k++) blk_q.push_back($urandom);
      run_block(1'b1, 1, "after_rst", 1'b0, 16'h0, d_emit, d_ack, d_oe);
      check("after_rst_bits", 32'(d_emit), 32'd42);
      check("after_rst_acks", 32'(d_ack), 32'd3);

      // start with zero words is ignored.
      a0 = ack_cnt;
      pulse_start(1'b1, 0);
      tick();
      check("zero_busy", 32'(busy_o), 32'd0);
      tick();
      check("zero_acks", 32'(ack_cnt - a0), 32'd0);

      // start while busy is ignored.
      en_period = 1;
      blk_q.delete();
      for (int k = 0; k < 2; k++) blk_q.push_back($urandom);
      build_expected(1'b1, 1'b0, 16'h0);
      foreach (blk_q[k]) src_q.push_back(blk_q[k]);
      e0 = emitted; a0 = ack_cnt;
      pulse_start(1'b1, 2);
      repeat (6) tick();
      pulse_start(1'b0, 5);
      wait_done(500, "busy_start");
      check("busy_start_bits", 32'(emitted - e0), 32'd34);
      check("busy_start_acks", 32'(ack_cnt - a0), 32'd2);

      // 4-bit, 4 words, bit_en every 3rd cycle: each value held 3 cycles.
      blk_q.delete();
      for (int k = 0; k < 4; k++) blk_q.push_back($urandom);
      run_block(1'b1, 3, "slow", 1'b0, 16'h0, d_emit, d_ack, d_oe);
      check("slow_bits", 32'(d_emit), 32'd50);
      check("slow_oe", 32'(d_oe), 32'd150);
      check("slow_acks", 32'(d_ack), 32'd4);

      // A few random blocks.
      for (int r = 0; r < 4; r++) begin
         wd  = 1'($urandom_range(0, 1));
         nw  = $urandom_range(1, 5);
         per = $urandom_range(1, 3);
         blk_q.delete();
         for (int k = 0; k < nw; k++) blk_q.push_back($urandom);
         run_block(wd, per, "rand", 1'b0, 16'h0, d_emit, d_ack, d_oe);
         check("rand_bits", 32'(d_emit), 32'(18 + nw * (wd ? 8 : 32)));
         check("rand_acks", 32'(d_ack), 32'(nw));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dat_serializer.md
DAT_SERIALIZER -- requirements
Module: dat_serializer

Interface
REQ-001 SHALL have parameter BLK_W, default 10, meaning width of the block word-count input (maximum 2^BLK_W - 1 words per block).
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port bit_en_i  input  1  SD bit-time strobe; one DAT bit-time elapses per clk cycle with bit_en_i=1.
REQ-005 SHALL have port start_i  input  1  single-cycle request to transmit one block.
REQ-006 SHALL have port wide_i  input  1  bus width: 0 = 1-bit (DAT0), 1 = 4-bit (DAT3..0); sampled with start_i.
REQ-007 SHALL have port words_i  input  BLK_W  words in the block; sampled with start_i.
REQ-008 SHALL have port word_i  input  32  data word from the buffer.
REQ-009 SHALL have port word_valid_i  input  1  word_i holds valid data.
REQ-010 SHALL have port word_ack_o  output  1  one-cycle pulse; word_i is consumed in this cycle.
REQ-011 SHALL have port dat_o  output  4  DAT line values.
REQ-012 SHALL have port dat_oe_o  output  1  DAT driver enable.
REQ-013 SHALL have port busy_o  output  1  block in progress.
REQ-014 SHALL have port stall_o  output  1  data underrun; the host SHALL stop sd_clk while it is high.
REQ-015 SHALL have port done_o  output  1  one-cycle pulse after the end bit.

Function
REQ-016 SHALL implement states IDLE, FETCH, START, DATA, CRC, END.
REQ-017 In IDLE, start_i=1 with words_i != 0 SHALL latch wide_i and words_i, assert busy_o and go to FETCH; start_i with words_i = 0 SHALL be ignored.
REQ-018 start_i while busy_o=1 SHALL be ignored.
REQ-019 In FETCH, word_valid_i=1 SHALL load the shift register, pulse word_ack_o and go to START; otherwise the state SHALL hold.
REQ-020 In START, at bit_en_i, dat_o SHALL be 0 on the active lines with dat_oe_o=1; the state SHALL then go to DATA.
REQ-021 In DATA, 1-bit mode SHALL output one bit per bit-time on dat_o[0], MSB first (word bit 31 first).
REQ-022 In DATA, 4-bit mode SHALL output one nibble per bit-time, MSB nibble first, with dat_o[3] = higher bit.
REQ-023 Inactive lines in 1-bit mode SHALL drive 1.
REQ-024 The next word SHALL be fetched (word_ack_o pulse) in the cycle the last bit or nibble of the current word is emitted, if word_valid_i=1 and words remain.
REQ-025 If a word is needed but word_valid_i=0, stall_o SHALL assert, dat_o SHALL hold and bit_en_i SHALL be ignored until word_valid_i=1. The word SHALL then be acked, stall_o SHALL deassert and shifting SHALL resume with no bit lost or repeated.
REQ-026 Each active line SHALL keep an independent CRC16 (x^16+x^12+x^5+1, init 0) over its data bits only.
REQ-027 After the last data bit, CRC SHALL shift the 16 CRC bits out MSB first on each active line, over 16 bit-times.
REQ-028 END SHALL drive 1 on all active lines for one bit-time. The following cycle SHALL clear busy_o and dat_oe_o, pulse done_o and return to IDLE.
REQ-029 The bit counter SHALL count 32 bits per word (1-bit mode) or 8 nibbles per word (4-bit mode); the word counter SHALL decrement per acked word and end DATA at 0.
REQ-030 Total bit-times per block SHALL be 1 + words*32 + 16 + 1 (1-bit mode) or 1 + words*8 + 16 + 1 (4-bit mode), excluding stall time.
REQ-031 Outside START/DATA/CRC/END, dat_o SHALL be 4'hF and dat_oe_o SHALL be 0.
REQ-032 Outputs SHALL change only in cycles with bit_en_i=1, except word_ack_o, stall_o, busy_o and done_o.

Reset
REQ-033 reset=1 SHALL force IDLE from any state, including mid-block, with no done_o pulse.
REQ-034 reset=1 SHALL set dat_o=4'hF, dat_oe_o=0, busy_o=0, stall_o=0, word_ack_o=0, done_o=0, clear all CRC registers and clear all counters.
REQ-035 reset SHALL take priority over start_i in the same cycle.

Verification
REQ-036 1-bit mode, words=128 all 32'hFFFFFFFF, bit_en_i=1 constant -> DAT0: 0, then 4096 ones, then CRC 16'h7FA1, then 1; done_o pulse; exactly 4114 bit-times.
REQ-037 4-bit mode, words=1, word 32'h12345678 -> dat_o sequence 0,1,2,3,4,5,6,7,8, then 16 CRC nibbles, then F; total 26 bit-times; one word_ack_o.
REQ-038 1-bit mode, words=2, word_valid_i low for 10 cycles at the word boundary -> stall_o high for exactly that period, dat_o frozen; serial stream identical to the no-stall run.
REQ-039 reset asserted during CRC state -> next cycle dat_oe_o=0, dat_o=F, busy_o=0, no done_o; a new start_i then runs a full correct block.
REQ-040 start_i with words_i=0, and start_i while busy_o=1 -> no state change, no word_ack_o.
REQ-041 bit_en_i=1 every 3rd cycle, 4-bit mode, words=4 -> same dat_o sequence as continuous enable, each value held 3 clk cycles.
